step_controller: RTL and testbench
==================================

STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 26, meaning divider counter width.
REQ-002 The block SHALL have parameter BURST_W, default 4, meaning width of burst_len.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2097151, meaning idle cycles between burst pulses (legal range 1..2^CNT_W-1).
REQ-004 The block SHALL have port CLOCK_40, input, 1 bit: the single system clock; all logic rises on it.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port select, input, 3 bits: speed index into SPEED_TABLE.
REQ-007 The block SHALL have port trigger, input, 1 bit: single-step request, rising-edge sensitive.
REQ-008 The block SHALL have port multitrigger, input, 1 bit: burst request, rising-edge sensitive.
REQ-009 The block SHALL have port burst_len, input, BURST_W bits: pulses per burst, sampled on the multitrigger edge.
REQ-010 The block SHALL have port halt, input, 1 bit: CPU stop request, level-sensitive.
REQ-011 The block SHALL have port resume, input, 1 bit: leave HALTED, rising-edge sensitive.
REQ-012 The block SHALL have port enable, output, 1 bit: one-cycle execute strobe.
REQ-013 The block SHALL have port burst_active, output, 1 bit: high while in BURST.
REQ-014 The block SHALL have port halted, output, 1 bit: high while in HALTED.
REQ-015 The block SHALL have port pulse_count, output, 16 bits: enable pulses issued since reset, wrapping.

Function
REQ-016 States SHALL be MANUAL, RUN, BURST and HALTED; D = SPEED_TABLE[select], where D=0 means manual.
REQ-017 In RUN, the CNT_W-bit counter SHALL increment each cycle; when counter == D, enable=1 for one cycle, the counter returns to 0, and the period is D+1 cycles.
REQ-018 A change of select from the previous cycle SHALL clear the counter and suppress enable that cycle; next state is RUN if D!=0, else MANUAL.
REQ-019 In MANUAL, a trigger rising edge SHALL produce enable=1 on the following cycle, exactly once per edge.
REQ-020 In MANUAL, a multitrigger rising edge SHALL enter BURST with N = burst_len, where burst_len 0 is treated as 1; the first enable comes on the following cycle, with subsequent enables spaced GAP_CYCLES+1 cycles apart; exit to MANUAL after the Nth pulse.
REQ-021 trigger and multitrigger edges SHALL be ignored in RUN, BURST and HALTED; if both edges occur in the same cycle in MANUAL, trigger wins.
REQ-022 Leaving manual mode (select to D!=0) mid-burst SHALL abandon the burst with no further pulses.
REQ-023 halt=1 in any state SHALL enter HALTED next cycle: enable forced 0 that cycle onward, counter cleared, burst abandoned.
REQ-024 HALTED SHALL exit only on a resume rising edge while halt=0, going to RUN or MANUAL per current D; if halt and resume are both high, halt wins.
REQ-025 enable SHALL never be high on two consecutive cycles.
REQ-026 pulse_count SHALL increment on every enable cycle, wrapping from 16'hFFFF to 0.
REQ-027 All outputs SHALL be registered; inputs are treated as already synchronous to CLOCK_40.

Reset
REQ-028 reset SHALL force enable=0, burst_active=0, halted=0, pulse_count=0, counter=0, and burst count=0.
REQ-029 After reset, the state SHALL be MANUAL and is re-evaluated from select on the first cycle after reset.
REQ-030 reset SHALL load the edge-detect history registers with 1 so a button held through reset generates no pulse.
REQ-031 reset asserted mid-burst or mid-count SHALL take effect on the next edge, with no trailing pulse.

Structure
REQ-032 Package step_pkg SHALL hold the state enum and the SPEED_TABLE constant array {0, 5000000, 1000000, 50000, 6000, 2500, 50, 5}.
REQ-033 A sub-module rise_detect (1-bit, reset-preset history) SHALL be instantiated for trigger, multitrigger and resume.

Verification
REQ-034 With select=7, run 30 cycles -> enable pulses every 6 cycles, pulse_count=5.
REQ-035 With select=0, pulse trigger high for 4 cycles -> exactly one enable, 1 cycle after the edge.
REQ-036 With GAP_CYCLES=3, burst_len=3, and a multitrigger edge -> enables at edge+1, +5, +9; burst_active drops after the third enable; a trigger edge during the burst is ignored.
REQ-037 With select=7, assert halt 1 cycle, then pulse resume -> no enable while halted; halted=1 until the cycle after the resume edge; counting restarts from 0.
REQ-038 With select=0 and a burst of 3 in progress, switch to select=7 after the first pulse -> no further burst pulses; RUN period of 6 cycles.
REQ-039 Hold trigger=1 through reset release -> no enable; a later re-press yields one pulse.

Source files
------------

// File: rtl/step_pkg.sv
// Shared types and constants for the step controller.
// Holds the mode encoding and the speed lookup table.
package step_pkg;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      RUN    = 2'd1,
      BURST  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam int unsigned SPEED_TABLE [8] = '{
      0,
      5000000,
      1000000,
      50000,
      6000,
      2500,
      50,
      5
   };

   function automatic int unsigned speed_of(input logic [2:0] sel);
      return SPEED_TABLE[sel];
   endfunction

endpackage

// File: rtl/step_controller_rise_detect.sv
// Single-bit rising-edge detector whose history presets to 1 on reset,
// so an input already high at reset release produces no edge.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic hist;

   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= 1'b1;
      end else begin
         hist <= sig;
      end
   end

   assign rise = sig & ~hist;

endmodule

// File: rtl/step_controller.sv
// CPU clock-enable generator: free-running speeds, single step,
// gap-spaced bursts and a halt/resume hold, all on CLOCK_40.
module step_controller
   import step_pkg::*;
#(
   parameter int CNT_W      = 26,
   parameter int BURST_W    = 4,
   parameter int GAP_CYCLES = 2097151
) (
   input  logic               CLOCK_40,
   input  logic               reset,
   input  logic [2:0]         select,
   input  logic               trigger,
   input  logic               multitrigger,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               halt,
   input  logic               resume,
   output logic               enable,
   output logic               burst_active,
   output logic               halted,
   output logic [15:0]        pulse_count
);

   localparam logic [CNT_W-1:0] GAP = CNT_W'(GAP_CYCLES);

   state_t state;
   state_t state_n;

   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_n;
   logic [CNT_W-1:0]   gap;
   logic [CNT_W-1:0]   gap_n;
   logic [BURST_W-1:0] left;
   logic [BURST_W-1:0] left_n;
   logic [2:0]         select_q;
   logic               en_n;

   logic [CNT_W-1:0]   d;
   logic               manual;
   logic               sel_chg;

   logic trig_rise;
   logic multi_rise;
   logic resume_rise;

   rise_detect u_trig (
      .clk   (CLOCK_40),
      .reset (reset),
      .sig   (trigger),
      .rise  (trig_rise)
   );

   rise_detect u_multi (
      .clk   (CLOCK_40),
      .reset (reset),
      .sig   (multitrigger),
      .rise  (multi_rise)
   );

   rise_detect u_resume (
      .clk   (CLOCK_40),
      .reset (reset),
      .sig   (resume),
      .rise  (resume_rise)
   );

   assign d       = CNT_W'(speed_of(select));
   assign manual  = (d == '0);
   assign sel_chg = (select != select_q);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gap_n   = gap;
      left_n  = left;
      en_n    = 1'b0;

      if (halt) begin
         state_n = HALTED;
         cnt_n   = '0;
         gap_n   = '0;
         left_n  = '0;
      end else if (state == HALTED) begin
         cnt_n  = '0;
         gap_n  = '0;
         left_n = '0;
         if (resume_rise) begin
            state_n = manual ? MANUAL : RUN;
         end
      end else if (sel_chg) begin
         cnt_n   = '0;
         gap_n   = '0;
         left_n  = '0;
         state_n = manual ? MANUAL : RUN;
      end else if (!manual) begin
         // Speed mode counts in any non-halted state, so the
         // first period after reset is a full D+1 cycles.
         state_n = RUN;
         gap_n   = '0;
         left_n  = '0;
         if (cnt == d) begin
            cnt_n = '0;
            en_n  = 1'b1;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
      end else begin
         cnt_n = '0;
         unique case (state)
            BURST: begin
               if (left == '0) begin
                  state_n = MANUAL;
                  gap_n   = '0;
               end else if (gap == GAP) begin
                  en_n   = 1'b1;
                  gap_n  = '0;
                  left_n = left - BURST_W'(1);
               end else begin
                  gap_n = gap + CNT_W'(1);
               end
            end
            default: begin
               state_n = MANUAL;
               // An edge landing while enable is high is dropped so
               // two strobes can never be back to back.
               if (!enable) begin
                  if (trig_rise) begin
                     en_n = 1'b1;
                  end else if (multi_rise) begin
                     en_n    = 1'b1;
                     state_n = BURST;
                     gap_n   = '0;
                     if (burst_len == '0) begin
                        left_n = '0;
                     end else begin
                        left_n = burst_len - BURST_W'(1);
                     end
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_40) begin
      if (reset) begin
         state        <= MANUAL;
         cnt          <= '0;
         gap          <= '0;
         left         <= '0;
         select_q     <= select;
         enable       <= 1'b0;
         burst_active <= 1'b0;
         halted       <= 1'b0;
         pulse_count  <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         gap          <= gap_n;
         left         <= left_n;
         select_q     <= select;
         enable       <= en_n;
         burst_active <= (state_n == BURST);
         halted       <= (state_n == HALTED);
         pulse_count  <= pulse_count + 16'(en_n);
      end
   end

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with GAP_CYCLES=3.
// Expected enable positions are hand-derived per scenario.
module tb_step_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  select;
   logic        trigger;
   logic        multitrigger;
   logic [3:0]  burst_len;
   logic        halt;
   logic        resume;
   logic        enable;
   logic        burst_active;
   logic        halted;
   logic [15:0] pulse_count;

   int checks   = 0;
   int failures = 0;
   int consec   = 0;
   logic prev_en = 1'b0;
   logic [31:0] m;

   always #5 clk = ~clk;

   step_controller #(
      .CNT_W      (26),
      .BURST_W    (4),
      .GAP_CYCLES (3)
   ) dut (
      .CLOCK_40     (clk),
      .reset        (reset),
      .select       (select),
      .trigger      (trigger),
      .multitrigger (multitrigger),
      .burst_len    (burst_len),
      .halt         (halt),
      .resume       (resume),
      .enable       (enable),
      .burst_active (burst_active),
      .halted       (halted),
      .pulse_count  (pulse_count)
   );

   always @(negedge clk) begin
      if (enable && prev_en) consec <= consec + 1;
      prev_en <= enable;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      select = 3'd7;
      trigger = 1'b0;
      multitrigger = 1'b0;
      burst_len = 4'd0;
      halt = 1'b0;
      resume = 1'b0;
      tick();
      tick();
      check("rst_enable", 32'(enable), 0);
      check("rst_burst", 32'(burst_active), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_count", 32'(pulse_count), 0);

      // select=7: period 6, first pulse 6 cycles after release
      reset = 1'b0;
      m = '0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (enable) m[i] = 1'b1;
      end
      check("run_mask", m, 32'h4104_1040);
      check("run_count", 32'(pulse_count), 5);

      // halt one cycle, then resume
      halt = 1'b1;
      tick();
      check("halt_flag", 32'(halted), 1);
      check("halt_en", 32'(enable), 0);
      halt = 1'b0;
      m = '0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (enable) m[i] = 1'b1;
      end
      check("halt_quiet", m, 0);
      check("halt_hold", 32'(halted), 1);
      resume = 1'b1;
      tick();
      check("resume_exit", 32'(halted), 0);
      resume = 1'b0;
      m = '0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (enable) m[i] = 1'b1;
      end
      check("resume_mask", m, 32'h0000_1040);
      check("resume_count", 32'(pulse_count), 7);

      // manual single step, trigger held 4 cycles
      select = 3'd0;
      tick();
      tick();
      trigger = 1'b1;
      m = '0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 5) trigger = 1'b0;
         tick();
         if (enable) m[i] = 1'b1;
      end
      check("step_mask", m, 32'h0000_0002);
      check("step_count", 32'(pulse_count), 8);

      // burst of 3, trigger during burst ignored
      burst_len = 4'd3;
      multitrigger = 1'b1;
      m = '0;
      for (int i = 1; i <= 14; i++) begin
         if (i == 3) begin
            multitrigger = 1'b0;
            trigger = 1'b1;
         end
         if (i == 4) trigger = 1'b0;
         tick();
         if (enable) m[i] = 1'b1;
         if (i == 9) check("burst_last_act", 32'(burst_active), 1);
         if (i == 10) check("burst_drop", 32'(burst_active), 0);
      end
      check("burst_mask", m, 32'h0000_0222);
      check("burst_count", 32'(pulse_count), 11);

      // burst abandoned by switching to select=7
      multitrigger = 1'b1;
      m = '0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 2) multitrigger = 1'b0;
         if (i == 3) select = 3'd7;
         tick();
         if (enable) m[i] = 1'b1;
         if (i == 3) check("abandon_act", 32'(burst_active), 0);
      end
      check("abandon_mask", m, 32'h0000_8202);
      check("abandon_count", 32'(pulse_count), 14);

      // trigger held through reset release
      reset = 1'b1;
      select = 3'd0;
      trigger = 1'b1;
      tick();
      tick();
      check("rst2_count", 32'(pulse_count), 0);
      reset = 1'b0;
      m = '0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (enable) m[i] = 1'b1;
      end
      check("held_mask", m, 0);
      trigger = 1'b0;
      tick();
      trigger = 1'b1;
      tick();
      check("repress_en", 32'(enable), 1);
      check("repress_count", 32'(pulse_count), 1);
      trigger = 1'b0;
      tick();
      check("repress_off", 32'(enable), 0);

      // burst_len 0 acts as a single pulse
      burst_len = 4'd0;
      multitrigger = 1'b1;
      m = '0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 2) multitrigger = 1'b0;
         tick();
         if (enable) m[i] = 1'b1;
         if (i == 1) check("b0_act", 32'(burst_active), 1);
         if (i == 2) check("b0_drop", 32'(burst_active), 0);
      end
      check("b0_mask", m, 32'h0000_0002);
      check("b0_count", 32'(pulse_count), 2);

      // reset mid-burst leaves no trailing pulse
      burst_len = 4'd2;
      multitrigger = 1'b1;
      tick();
      check("mid_first", 32'(enable), 1);
      multitrigger = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      m = '0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 3) reset = 1'b0;
         tick();
         if (enable) m[i] = 1'b1;
      end
      check("mid_rst_mask", m, 0);
      check("mid_rst_act", 32'(burst_active), 0);
      check("mid_rst_count", 32'(pulse_count), 0);

      check("no_consec", 32'(consec), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
